// File: rtl/uart_rx_param.sv
// uart_rx_param: 16x-oversampled UART receiver with majority-vote bit sampling feeding a first-word-fall-through FIFO.
// Optional parity bit compiled in with `UART_RX_PARITY_EN; the serial line cannot be stalled, so a full FIFO drops the word and pulses overrun.
module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [DIV_W-1:0]  div,
  input  logic              odd_par,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic              rx_m_q, rx_m_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]        samp_q, samp_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  logic tick, mid, bit_end, maj, push, push_ok, pop;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
`else
  logic unused_odd_par;
  assign unused_odd_par = odd_par;
`endif

  // Tick 9 is the third of the three mid-bit samples, so the vote uses the live value.
  assign tick    = (state_q != IDLE) && (cnt_q == div_q - DIV_W'(1));
  assign mid     = tick && (tick_cnt_q == 4'd9);
  assign bit_end = tick && (tick_cnt_q == 4'd15);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_comb begin
    state_d      = state_q;
    rx_m_d       = rx;
    rx_s_d       = rx_m_q;
    rx_prev_d    = rx_s_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    push         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd7) samp_d[0] = rx_s_q;
        if (tick_cnt_q == 4'd8) samp_d[1] = rx_s_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d    = START;
          div_d      = (div == '0) ? DIV_W'(1) : div;
          cnt_d      = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (mid && maj) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (mid) shift_d = {shift_q[DATA_W-2:0], maj};
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) par_d = maj;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Leave right after the mid-stop vote so a back-to-back start edge is not missed.
        if (mid) begin
          state_d = IDLE;
          if (!maj) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_q != ((^shift_q) ^ odd_par)) parity_err_d = 1'b1;
`endif
          else push = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  always_comb begin
    pop       = rd_en && (count_q != '0);
    push_ok   = push && ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);
    overrun_d = push && !push_ok;
    mem_d     = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_m_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_q        <= DIV_W'(1);
      cnt_q        <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_m_q       <= rx_m_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rd_data   = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: serial frames built from the frame format, expected words queued at issue, popped by a monitor.
module tb_uart_rx_param;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx = 1'b1;
  logic [DIV_W-1:0]  div = 16'd4;
  logic              odd_par = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              empty, full, busy, frame_err, parity_err, overrun;

  uart_rx_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .div(div), .odd_par(odd_par), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  logic [DATA_W-1:0] exp_q[$];
  int n_pop = 0, cnt_ferr = 0, cnt_perr = 0, cnt_ovr = 0;
  int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
  bit rd_auto = 1'b1;
  bit hold = 1'b0;
  int model_occ = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_rd_data"}, rd_data, 0);
    check({pfx, "_empty"}, empty, 1);
    check({pfx, "_full"}, full, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_frame_err"}, frame_err, 0);
    check({pfx, "_parity_err"}, parity_err, 0);
    check({pfx, "_overrun"}, overrun, 0);
  endtask

  // Monitor: counts flag pulses and pops/compares every word the DUT presents.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      cnt_ferr += int'(frame_err);
      cnt_perr += int'(parity_err);
      cnt_ovr  += int'(overrun);
      if (rd_auto && !empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h, required no word", rd_data);
        end else begin
          check("rx_word", rd_data, exp_q.pop_front());
        end
        n_pop++;
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end else begin
      rd_en = 1'b0;
    end
  end

  // Frame bits in line order: start, data MSB first, optional parity, stop.
  function automatic int build(input logic [DATA_W-1:0] d, input bit stop, input bit par_bad,
                               output logic [31:0] fb);
    int n = 0;
    fb = '1;
    fb[n] = 1'b0; n++;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb[n] = d[i]; n++;
    end
`ifdef UART_RX_PARITY_EN
    fb[n] = (^d) ^ odd_par ^ par_bad; n++;
`else
    if (par_bad) fb[n] = 1'b1;
`endif
    fb[n] = stop; n++;
    return n;
  endfunction

  task automatic drive_bits(input logic [31:0] fb, input int n, input int de);
    for (int i = 0; i < n; i++) begin
      rx = fb[i];
      repeat (16 * de) @(negedge clk);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit stop, input bit par_bad, input int gap);
    logic [31:0] fb;
    int n, de;
    bit pb;
    pb = par_bad;
`ifndef UART_RX_PARITY_EN
    pb = 1'b0;
`endif
    de = (div == '0) ? 1 : int'(div);
    n = build(d, stop, pb, fb);
    if (!stop) exp_ferr++;
    else if (pb) exp_perr++;
    else if (hold && model_occ == FIFO_DEPTH) exp_ovr++;
    else begin
      exp_q.push_back(d);
      if (hold) model_occ++;
    end
    @(negedge clk);
    drive_bits(fb, n, de);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (exp_q.size() != 0 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, exp_lat, b, pops0, ferr0, ovr0;
    logic [31:0] fb;
    int nb;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 at div=4: two sync flops plus the detect edge, then tick 9 of the stop bit.
    div = 16'd4;
`ifdef UART_RX_PARITY_EN
    exp_lat = 3 + (16 * (DATA_W + 2) + 10) * 4;
`else
    exp_lat = 3 + (16 * (DATA_W + 1) + 10) * 4;
`endif
    lat = 0;
    fork
      send(8'hA5, 1'b1, 1'b0, 40);
      begin
        @(negedge clk);
        while (empty && lat < 3000) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
      end
    join
    // One clock of slack covers where the line edge lands relative to the synchronizer.
    check("a5_latency_window", (lat >= exp_lat - 1 && lat <= exp_lat + 1), 1);
    drain("a5_drain");
    check("a5_no_frame_err", cnt_ferr, 0);
    check("a5_no_overrun", cnt_ovr, 0);

    // 8-clock low glitch is only two ticks long, so the mid-bit vote sees 1.
    pops0 = n_pop;
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_seen", busy, 1);
    b = 0;
    while (busy && b < 400) begin
      @(negedge clk);
      b++;
    end
    check("glitch_busy_clear", busy, 0);
    check("glitch_empty", empty, 1);
    check("glitch_no_word", n_pop, pops0);
    check("glitch_no_flag", cnt_ferr, exp_ferr);

    // Stop bit low: one frame_err, word discarded.
    pops0 = n_pop;
    ferr0 = cnt_ferr;
    send(8'h3C, 1'b0, 1'b0, 20);
    check("ferr_pulse_count", cnt_ferr - ferr0, 1);
    check("ferr_no_word", n_pop, pops0);
    check("ferr_empty", empty, 1);

`ifdef UART_RX_PARITY_EN
    odd_par = 1'b1;
    send(8'h01, 1'b1, 1'b1, 20);
    check("perr_pulse", cnt_perr, exp_perr);
    check("perr_empty", empty, 1);
    send(8'h01, 1'b1, 1'b0, 20);
    drain("perr_good_drain");
    odd_par = 1'b0;
`endif

    // Fill: five back-to-back frames into a four-deep FIFO with reads held off.
    rd_auto = 1'b0;
    repeat (2) @(negedge clk);
    hold = 1'b1;
    model_occ = 0;
    ovr0 = cnt_ovr;
    for (int i = 1; i <= 5; i++) send(DATA_W'(8'h11 * i), 1'b1, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("fill_full", full, 1);
    check("fill_overrun_count", cnt_ovr - ovr0, 1);
    check("fill_head", rd_data, 8'h11);
    hold = 1'b0;
    rd_auto = 1'b1;
    drain("fill_drain");
    check("fill_empty_after", empty, 1);
    check("fill_full_after", full, 0);

    // Reset in the middle of data bit 3 with one word already buffered.
    rd_auto = 1'b0;
    repeat (2) @(negedge clk);
    hold = 1'b1;
    model_occ = 0;
    send(8'h99, 1'b1, 1'b0, 8);
    check("mid_rst_buffered", empty, 0);
    div = 16'd4;
    nb = build(8'h5A, 1'b1, 1'b0, fb);
    @(negedge clk);
    drive_bits(fb, 4, 4);
    rx = fb[4];
    repeat (32) @(negedge clk);
    check("mid_rst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    exp_q.delete();
    model_occ = 0;
    hold = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    rd_auto = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h7E, 1'b1, 1'b0, 20);
    drain("after_rst_7e");

    // Randomized frames: divisor (0 acts as 1), data, stop, parity corruption, gaps.
    for (int i = 0; i < 24; i++) begin
      div = DIV_W'($urandom_range(0, 4));
      odd_par = 1'($urandom_range(0, 1));
      send(DATA_W'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
           $urandom_range(4, 40));
    end
    drain("random_drain");
    check("total_frame_err", cnt_ferr, exp_ferr);
    check("total_parity_err", cnt_perr, exp_perr);
    check("total_overrun", cnt_ovr, exp_ovr);
    check("final_empty", empty, 1);
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (legal 5..16).
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO words (power of 2, >=2).
REQ-003 Parameter DIV_W, default 16, width of baud divisor.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 div  input  DIV_W  clocks per oversample tick (16 ticks per bit).
REQ-008 odd_par  input  1  1 = odd parity, 0 = even (used only when parity compiled in).
REQ-009 rd_en  input  1  pop FIFO head.
REQ-010 rd_data  output  DATA_W  FIFO head word, first-word fall-through.
REQ-011 empty  output  1  FIFO empty.
REQ-012 full  output  1  FIFO full.
REQ-013 busy  output  1  receiver not in IDLE.
REQ-014 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-015 parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-016 overrun  output  1  one-cycle pulse, good word dropped because FIFO full.

Function
REQ-017 rx SHALL pass a 2-flop synchronizer (reset value 1); all decisions use synchronized rx_s.
REQ-018 Frame SHALL be: start bit 0, DATA_W data bits MSB first, optional parity bit, one stop bit 1.
REQ-019 div SHALL be latched on start detection and held for the whole frame; div==0 SHALL behave as div==1.
REQ-020 Tick generator SHALL pulse once every latched-div clocks, restarting phase at start detection.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE: a 1->0 transition of rx_s SHALL enter START with tick and bit counters cleared.
REQ-023 Each bit SHALL be sampled at ticks 7, 8, 9 of its 16; bit value = majority of the three.
REQ-024 START: sampled value 1 SHALL be a false start -> IDLE, no flag, nothing stored.
REQ-025 DATA: after DATA_W bits -> PARITY if compiled in, else STOP.
REQ-026 STOP: FSM SHALL return to IDLE on the clock after the mid-stop sample (tick 9), enabling back-to-back frames.
REQ-027 Stop sampled 0 SHALL pulse frame_err and discard the word; frame_err takes precedence over parity_err.
REQ-028 Good word SHALL be pushed so empty deasserts and rd_data is valid 1 clock after the mid-stop sample.
REQ-029 rd_en with empty=1 SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-030 Push while full SHALL succeed only if rd_en is asserted the same cycle; otherwise word dropped, overrun pulses, FIFO contents unchanged.
REQ-031 Simultaneous push and pop on non-full FIFO SHALL leave occupancy unchanged.

Reset
REQ-032 rst_n low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1, FIFO empty, rd_data 0, empty 1, full 0, busy 0, all flag pulses 0.
REQ-033 Reset mid-frame SHALL abort the frame with no flag; receiver re-arms on next falling edge after release.

Configuration
REQ-034 Macro UART_RX_PARITY_EN defined: PARITY state present; parity per odd_par; mismatch pulses parity_err and discards the word.
REQ-035 Macro undefined: no PARITY state, odd_par ignored, parity_err tied 0, frame = DATA_W+2 bits.

Verification
REQ-036 div=4, DATA_W=8, frame 0xA5 -> rd_data=0xA5, empty falls 1 clock after mid-stop, no flags.
REQ-037 div=4, 1-clock-per-tick-period low glitch (8 clocks) on idle rx -> false start, FIFO stays empty, busy returns 0.
REQ-038 Frame 0x3C with stop bit 0 -> frame_err one pulse, empty stays 1.
REQ-039 With UART_RX_PARITY_EN, odd_par=1, 0x01 sent with parity 0 -> parity_err pulse, word discarded; parity 1 -> stored.
REQ-040 FIFO_DEPTH=4, 5 back-to-back frames 0x11..0x55, no reads -> full=1, overrun pulse on 5th, reads yield 0x11..0x44 then empty=1.
REQ-041 rst_n low during DATA bit 3 -> all outputs at reset values immediately; next frame 0x7E received correctly.
